// File: rtl/wt_dcache_mshr.sv
// Miss-status holding registers for the write-through L1 D$: per-miss transaction IDs,
// secondary-miss detection and return lookup. Define WT_DCACHE_MSHR_MERGE_EN to merge secondary misses.
module wt_dcache_mshr #(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned NumPorts   = 3,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned IdBase     = 1,
  parameter int unsigned PlenWidth  = 56,
  parameter int unsigned OffWidth   = 4,
  localparam int unsigned PortW     = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int unsigned CntW      = $clog2(NumEntries + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_req_i,
  input  logic [PlenWidth-1:0] alloc_paddr_i,
  input  logic [PortW-1:0]     alloc_port_i,
  input  logic                 alloc_nc_i,
  output logic                 alloc_gnt_o,
  output logic                 alloc_new_o,
  output logic [IdWidth-1:0]   alloc_id_o,
  input  logic                 rtrn_vld_i,
  input  logic [IdWidth-1:0]   rtrn_id_i,
  output logic                 rtrn_hit_o,
  output logic [NumPorts-1:0]  rtrn_ports_o,
  output logic [PlenWidth-1:0] rtrn_paddr_o,
  output logic                 rtrn_nc_o,
  output logic                 rtrn_err_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CntW-1:0]      pending_o
);

  localparam int unsigned LineW = PlenWidth - OffWidth;
  localparam int unsigned EntW  = (NumEntries > 1) ? $clog2(NumEntries) : 1;

  typedef enum logic {FREE, BUSY} ent_state_e;

  ent_state_e          state_q [NumEntries];
  ent_state_e          state_d [NumEntries];
  logic [LineW-1:0]    line_q  [NumEntries];
  logic [LineW-1:0]    line_d  [NumEntries];
  logic [PlenWidth-1:0] paddr_q [NumEntries];
  logic [PlenWidth-1:0] paddr_d [NumEntries];
  logic                nc_q    [NumEntries];
  logic                nc_d    [NumEntries];
  logic [NumPorts-1:0] ports_q [NumEntries];
  logic [NumPorts-1:0] ports_d [NumEntries];
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [LineW-1:0]      alloc_line;
  logic [NumEntries-1:0] hitv;
  logic [NumEntries-1:0] lm;
  logic [NumPorts-1:0]   port_oh;
  logic                  stall, lm_any, f_any, merge_ok;
  logic [EntW-1:0]       m_idx, f_idx, sel_idx;

  assign alloc_line = alloc_paddr_i[PlenWidth-1:OffWidth];

  // State register: control state is reset, payload fields are not.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NumEntries; k++) begin
        state_q[k] <= FREE;
        ports_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NumEntries; k++) begin
        state_q[k] <= state_d[k];
        ports_q[k] <= ports_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NumEntries; k++) begin
      line_q[k]  <= line_d[k];
      paddr_q[k] <= paddr_d[k];
      nc_q[k]    <= nc_d[k];
    end
  end

  // Output logic: return lookup and grant arbitration.
  always_comb begin
    hitv         = '0;
    lm           = '0;
    port_oh      = '0;
    stall        = 1'b0;
    lm_any       = 1'b0;
    f_any        = 1'b0;
    merge_ok     = 1'b0;
    m_idx        = '0;
    f_idx        = '0;
    sel_idx      = '0;
    rtrn_hit_o   = 1'b0;
    rtrn_ports_o = '0;
    rtrn_paddr_o = '0;
    rtrn_nc_o    = 1'b0;
    alloc_gnt_o  = 1'b0;
    alloc_new_o  = 1'b0;
    alloc_id_o   = '0;

    for (int unsigned k = 0; k < NumEntries; k++) begin
      if (rtrn_vld_i && state_q[k] == BUSY && rtrn_id_i == IdWidth'(IdBase + k)) begin
        hitv[k]      = 1'b1;
        rtrn_hit_o   = 1'b1;
        rtrn_ports_o = ports_q[k];
        rtrn_paddr_o = paddr_q[k];
        rtrn_nc_o    = nc_q[k];
      end
    end
    rtrn_err_o = rst_ni && rtrn_vld_i && !rtrn_hit_o;

    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (alloc_port_i == PortW'(p)) port_oh[p] = 1'b1;
    end

    // A retiring entry cannot be matched, and its line may not be reopened until next cycle.
    for (int unsigned k = 0; k < NumEntries; k++) begin
      if (hitv[k] && line_q[k] == alloc_line) stall = 1'b1;
      lm[k] = (state_q[k] == BUSY) && (line_q[k] == alloc_line) && !hitv[k];
      if (!lm_any && lm[k]) begin
        lm_any = 1'b1;
        m_idx  = EntW'(k);
`ifdef WT_DCACHE_MSHR_MERGE_EN
        merge_ok = !alloc_nc_i && !nc_q[k] && ((ports_q[k] & port_oh) == '0);
`endif
      end
      if (!f_any && state_q[k] == FREE) begin
        f_any = 1'b1;
        f_idx = EntW'(k);
      end
    end

    if (rst_ni && alloc_req_i && !stall) begin
      if (lm_any) begin
        alloc_gnt_o = merge_ok;
        sel_idx     = m_idx;
      end else if (f_any) begin
        alloc_gnt_o = 1'b1;
        alloc_new_o = 1'b1;
        sel_idx     = f_idx;
      end
    end
    if (alloc_gnt_o) alloc_id_o = IdWidth'(IdBase) + IdWidth'(sel_idx);
  end

  // Next-state logic per entry and for the occupancy count.
  always_comb begin
    for (int unsigned k = 0; k < NumEntries; k++) begin
      state_d[k] = state_q[k];
      line_d[k]  = line_q[k];
      paddr_d[k] = paddr_q[k];
      nc_d[k]    = nc_q[k];
      ports_d[k] = ports_q[k];
      if (hitv[k]) begin
        state_d[k] = FREE;
        ports_d[k] = '0;
      end
      if (alloc_gnt_o && EntW'(k) == sel_idx) begin
        if (alloc_new_o) begin
          state_d[k] = BUSY;
          line_d[k]  = alloc_line;
          paddr_d[k] = alloc_paddr_i;
          nc_d[k]    = alloc_nc_i;
          ports_d[k] = port_oh;
        end else begin
          ports_d[k] = ports_q[k] | port_oh;
        end
      end
    end
    unique case ({alloc_new_o, rtrn_hit_o})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign pending_o = cnt_q;
  assign full_o    = (cnt_q == CntW'(NumEntries));
  assign empty_o   = (cnt_q == '0);

endmodule

// File: tb/tb_wt_dcache_mshr.sv
// Self-checking bench for wt_dcache_mshr: directed scenarios plus randomized traffic
// compared against an entry-table reference model.
module tb_wt_dcache_mshr;
  localparam int NE = 4, NP = 3, IW = 4, IB = 1, PW = 56, OW = 4;
  localparam logic [72:0] RST_VEC = 73'd8; // only empty=1

  logic          clk = 1'b0, rst_ni = 1'b0;
  logic          alloc_req_i = 1'b0, alloc_nc_i = 1'b0, rtrn_vld_i = 1'b0;
  logic [PW-1:0] alloc_paddr_i = '0;
  logic [1:0]    alloc_port_i = '0;
  logic [IW-1:0] rtrn_id_i = '0;
  logic          alloc_gnt_o, alloc_new_o, rtrn_hit_o, rtrn_nc_o, rtrn_err_o, full_o, empty_o;
  logic [IW-1:0] alloc_id_o;
  logic [NP-1:0] rtrn_ports_o;
  logic [PW-1:0] rtrn_paddr_o;
  logic [2:0]    pending_o;

  int checks = 0, errors = 0;

  wt_dcache_mshr #(.NumEntries(NE), .NumPorts(NP), .IdWidth(IW), .IdBase(IB),
                   .PlenWidth(PW), .OffWidth(OW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .alloc_req_i(alloc_req_i), .alloc_paddr_i(alloc_paddr_i), .alloc_port_i(alloc_port_i),
    .alloc_nc_i(alloc_nc_i), .alloc_gnt_o(alloc_gnt_o), .alloc_new_o(alloc_new_o),
    .alloc_id_o(alloc_id_o), .rtrn_vld_i(rtrn_vld_i), .rtrn_id_i(rtrn_id_i),
    .rtrn_hit_o(rtrn_hit_o), .rtrn_ports_o(rtrn_ports_o), .rtrn_paddr_o(rtrn_paddr_o),
    .rtrn_nc_o(rtrn_nc_o), .rtrn_err_o(rtrn_err_o), .full_o(full_o), .empty_o(empty_o),
    .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  // Reference model: a table of outstanding misses.
  bit            mv     [NE];
  logic [PW-1:0] mpaddr [NE];
  bit            mnc    [NE];
  logic [NP-1:0] mports [NE];
  int            mcnt;

  bit            e_gnt, e_new, e_hit, e_nc, e_err;
  logic [IW-1:0] e_id;
  logic [NP-1:0] e_ports;
  logic [PW-1:0] e_paddr;
  int            e_slot, e_ret, a_port;
  logic [PW-1:0] a_pa;
  bit            a_nc;

  function automatic logic [72:0] dut_vec();
    return {alloc_gnt_o, alloc_new_o, alloc_id_o, rtrn_hit_o, rtrn_ports_o, rtrn_paddr_o,
            rtrn_nc_o, rtrn_err_o, full_o, empty_o, pending_o};
  endfunction

  function automatic logic [72:0] exp_vec();
    logic [2:0] cnt = 3'(mcnt);
    return {e_gnt, e_new, e_id, e_hit, e_ports, e_paddr, e_nc, e_err,
            mcnt == NE, mcnt == 0, cnt};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NE; k++) begin mv[k] = 0; mports[k] = '0; end
    mcnt = 0;
  endtask

  task automatic apply(input bit req, input logic [PW-1:0] pa, input int port, input bit nc,
                       input bit rv, input int rid);
    int lmk = -1;
    alloc_req_i = req; alloc_paddr_i = pa; alloc_port_i = port[1:0]; alloc_nc_i = nc;
    rtrn_vld_i = rv; rtrn_id_i = rid[IW-1:0];
    a_pa = pa; a_port = port; a_nc = nc;
    e_ret = -1;
    if (rv && rid >= IB && rid < IB + NE && mv[rid-IB]) e_ret = rid - IB;
    e_hit = (e_ret >= 0);
    e_err = rv && !e_hit;
    e_ports = e_hit ? mports[e_ret] : '0;
    e_paddr = e_hit ? mpaddr[e_ret] : '0;
    e_nc    = e_hit ? mnc[e_ret] : 1'b0;
    e_gnt = 0; e_new = 0; e_id = '0; e_slot = -1;
    if (req && !(e_hit && (mpaddr[e_ret] >> OW) == (pa >> OW))) begin
      for (int k = 0; k < NE; k++)
        if (lmk < 0 && mv[k] && k != e_ret && (mpaddr[k] >> OW) == (pa >> OW)) lmk = k;
      if (lmk >= 0) begin
`ifdef WT_DCACHE_MSHR_MERGE_EN
        if (!nc && !mnc[lmk] && !mports[lmk][port]) begin e_gnt = 1; e_slot = lmk; end
`endif
      end else begin
        for (int k = 0; k < NE; k++)
          if (e_slot < 0 && !mv[k]) begin e_slot = k; e_gnt = 1; e_new = 1; end
      end
      if (e_gnt) e_id = IW'(e_slot + IB);
    end
    #4; // sample at the negedge
  endtask

  task automatic adv();
    @(posedge clk);
    if (e_ret >= 0) begin mv[e_ret] = 0; mports[e_ret] = '0; end
    if (e_gnt && e_new) begin
      mv[e_slot] = 1; mpaddr[e_slot] = a_pa; mnc[e_slot] = a_nc;
      mports[e_slot] = NP'(1) << a_port;
    end else if (e_gnt) begin
      mports[e_slot] = mports[e_slot] | (NP'(1) << a_port);
    end
    mcnt = mcnt + int'(e_gnt && e_new) - int'(e_hit);
    #1;
  endtask

  task automatic test_reset();
    alloc_req_i = 1; alloc_paddr_i = 56'h8000_0040; rtrn_vld_i = 1; rtrn_id_i = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), RST_VEC);
    end
    model_reset();
    rst_ni = 1;
    apply(0, '0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), exp_vec());
    end
    adv();
  endtask

  task automatic test_basic();
    apply(1, 56'h8000_0040, 1, 0, 0, 0);
    checks++;
    if ({alloc_gnt_o, alloc_new_o, alloc_id_o} !== {1'b1, 1'b1, 4'd1}) begin
      errors++; $display("FAIL basic_alloc: got %b%b id %0d expected 11 id 1", alloc_gnt_o, alloc_new_o, alloc_id_o);
    end
    adv();
    apply(0, '0, 0, 0, 0, 0);
    checks++;
    if (pending_o !== 3'd1 || empty_o !== 1'b0) begin
      errors++; $display("FAIL basic_pending: got %0d/%b expected 1/0", pending_o, empty_o);
    end
    adv();
    apply(0, '0, 0, 0, 1, 1);
    checks++;
    if ({rtrn_hit_o, rtrn_ports_o, rtrn_paddr_o} !== {1'b1, 3'b010, 56'h8000_0040}) begin
      errors++; $display("FAIL basic_rtrn: got %b %b %h expected 1 010 80000040", rtrn_hit_o, rtrn_ports_o, rtrn_paddr_o);
    end
    adv();
    apply(0, '0, 0, 0, 0, 0);
    checks++;
    if (empty_o !== 1'b1) begin
      errors++; $display("FAIL basic_empty: got %b expected 1", empty_o);
    end
    adv();
  endtask

  task automatic test_fill();
    for (int k = 0; k < NE; k++) begin
      apply(1, 56'h1000 * (k + 1), 0, 0, 0, 0);
      checks++;
      if (alloc_gnt_o !== 1'b1 || alloc_id_o !== IW'(k + 1)) begin
        errors++; $display("FAIL fill_id%0d: got gnt %b id %0d expected 1 %0d", k, alloc_gnt_o, alloc_id_o, k + 1);
      end
      adv();
    end
    apply(1, 56'h5000, 0, 0, 0, 0);
    checks++;
    if (full_o !== 1'b1 || alloc_gnt_o !== 1'b0) begin
      errors++; $display("FAIL fill_full: got full %b gnt %b expected 1 0", full_o, alloc_gnt_o);
    end
    adv();
    apply(1, 56'h5000, 0, 0, 1, 3);
    checks++;
    if (alloc_gnt_o !== 1'b0 || rtrn_hit_o !== 1'b1) begin
      errors++; $display("FAIL fill_no_bypass: got gnt %b hit %b expected 0 1", alloc_gnt_o, rtrn_hit_o);
    end
    adv();
    apply(1, 56'h5000, 0, 0, 0, 0);
    checks++;
    if ({alloc_gnt_o, alloc_new_o, alloc_id_o} !== {1'b1, 1'b1, 4'd3}) begin
      errors++; $display("FAIL fill_reuse: got %b%b id %0d expected 11 id 3", alloc_gnt_o, alloc_new_o, alloc_id_o);
    end
    adv();
    for (int k = 1; k <= NE; k++) begin
      apply(0, '0, 0, 0, 1, k);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL fill_drain%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      adv();
    end
  endtask

  task automatic test_merge();
    apply(1, 56'h100, 0, 0, 0, 0);
    adv();
    apply(1, 56'h108, 2, 0, 0, 0);
`ifdef WT_DCACHE_MSHR_MERGE_EN
    checks++;
    if ({alloc_gnt_o, alloc_new_o, alloc_id_o} !== {1'b1, 1'b0, 4'd1}) begin
      errors++; $display("FAIL merge_gnt: got %b%b id %0d expected 10 id 1", alloc_gnt_o, alloc_new_o, alloc_id_o);
    end
    adv();
    apply(0, '0, 0, 0, 1, 1);
    checks++;
    if (rtrn_ports_o !== 3'b101) begin
      errors++; $display("FAIL merge_ports: got %b expected 101", rtrn_ports_o);
    end
    adv();
`else
    checks++;
    if (alloc_gnt_o !== 1'b0) begin
      errors++; $display("FAIL nomerge_stall: got gnt %b expected 0", alloc_gnt_o);
    end
    adv();
    apply(1, 56'h108, 2, 0, 1, 1);
    checks++;
    if (alloc_gnt_o !== 1'b0 || rtrn_ports_o !== 3'b001) begin
      errors++; $display("FAIL nomerge_rtrn: got gnt %b ports %b expected 0 001", alloc_gnt_o, rtrn_ports_o);
    end
    adv();
    apply(1, 56'h108, 2, 0, 0, 0);
    checks++;
    if ({alloc_gnt_o, alloc_new_o, alloc_id_o} !== {1'b1, 1'b1, 4'd1}) begin
      errors++; $display("FAIL nomerge_regrant: got %b%b id %0d expected 11 id 1", alloc_gnt_o, alloc_new_o, alloc_id_o);
    end
    adv();
    apply(0, '0, 0, 0, 1, 1);
    adv();
`endif
  endtask

  task automatic test_nc();
    apply(1, 56'h200, 0, 0, 0, 0);
    adv();
    apply(1, 56'h200, 1, 1, 0, 0);
    checks++;
    if (alloc_gnt_o !== 1'b0) begin
      errors++; $display("FAIL nc_stall: got gnt %b expected 0", alloc_gnt_o);
    end
    adv();
    apply(1, 56'h200, 1, 1, 1, 1);
    checks++;
    if (alloc_gnt_o !== 1'b0 || rtrn_hit_o !== 1'b1) begin
      errors++; $display("FAIL nc_retire_stall: got gnt %b hit %b expected 0 1", alloc_gnt_o, rtrn_hit_o);
    end
    adv();
    apply(1, 56'h200, 1, 1, 0, 0);
    checks++;
    if ({alloc_gnt_o, alloc_new_o, alloc_id_o} !== {1'b1, 1'b1, 4'd1}) begin
      errors++; $display("FAIL nc_regrant: got %b%b id %0d expected 11 id 1", alloc_gnt_o, alloc_new_o, alloc_id_o);
    end
    adv();
    apply(0, '0, 0, 0, 1, 1);
    checks++;
    if (rtrn_nc_o !== 1'b1 || rtrn_ports_o !== 3'b010) begin
      errors++; $display("FAIL nc_rtrn: got nc %b ports %b expected 1 010", rtrn_nc_o, rtrn_ports_o);
    end
    adv();
  endtask

  task automatic test_err_reset();
    apply(0, '0, 0, 0, 1, 7);
    checks++;
    if ({rtrn_err_o, rtrn_hit_o, pending_o} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL err_oob: got err %b hit %b pend %0d expected 1 0 0", rtrn_err_o, rtrn_hit_o, pending_o);
    end
    adv();
    apply(0, '0, 0, 0, 0, 0);
    checks++;
    if (rtrn_err_o !== 1'b0 || pending_o !== 3'd0) begin
      errors++; $display("FAIL err_pulse: got err %b pend %0d expected 0 0", rtrn_err_o, pending_o);
    end
    adv();
    for (int k = 0; k < 3; k++) begin apply(1, 56'h3000 + 56'h40 * k, k, 0, 0, 0); adv(); end
    apply(1, 56'h9000, 0, 0, 1, 2);
    checks++;
    if (pending_o !== 3'd3) begin
      errors++; $display("FAIL err_three_pending: got %0d expected 3", pending_o);
    end
    rst_ni = 0;
    #1;
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++; $display("FAIL midop_reset: got %h expected %h", dut_vec(), RST_VEC);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_ni = 1;
    apply(0, '0, 0, 0, 1, 2);
    checks++;
    if (rtrn_err_o !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL dropped_id_err: got %h expected %h", dut_vec(), exp_vec());
    end
    adv();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      apply($urandom_range(0, 1) == 1, 56'h8000_0000 + 56'h10 * $urandom_range(0, 5) + 56'($urandom_range(0, 15)),
            $urandom_range(0, NP - 1), $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) < 4, $urandom_range(0, 6));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d: got %h expected %h", c, dut_vec(), exp_vec());
      end
      adv();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_fill();
    test_merge();
    test_nc();
    test_err_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
